traffic_ctrl_multi: RTL and testbench
=====================================

# traffic_ctrl_multi

Parametrised multi-approach traffic-light controller, the successor to the two-light-set `traffic_fsm`. It cycles right-of-way through `N_DIR` approaches, inserting yellow and all-red clearance phases between them. It adds a pedestrian request that shortens green and drives a walk signal, plus a maintenance flash mode. It sits behind the tick divider and drives the LED/gate outputs directly.

## Interface
- `N_DIR`, 2: number of approaches, ≥2
- `TW`, 8: width of the phase timer and `time_left`
- `GREEN_T`, 20: green duration in ticks, 1..2^TW-1
- `YELLOW_T`, 3: yellow duration in ticks, ≥1
- `ALLRED_T`, 2: all-red clearance in ticks, ≥1
- `MIN_GREEN`, 5: green remaining after a pedestrian request, 1..GREEN_T
- `DW`: localparam, `max(1, $clog2(N_DIR))`

- `clk`  in  1  single clock; all logic is on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `tick`  in  1  one-clock timebase pulse
- `ped_req`  in  1  pedestrian button, level or pulse, sampled every clock
- `flash_en`  in  1  maintenance mode request, level
- `phase`  out  2  current phase, `phase_t`
- `active_dir`  out  DW  approach that owns or last owned green
- `led_r`, `led_y`, `led_g`  out  N_DIR each  per-approach lamps
- `walk`  out  1  pedestrian walk lamp
- `time_left`  out  TW  ticks remaining in the current phase
- `ped_pending`  out  1  latched, unserved pedestrian request

## Operation
- Phases: `ALL_RED` (00), `GREEN` (01), `YELLOW` (10), `FLASH` (11).
- Normal cycle: `GREEN(d)` → `YELLOW(d)` → `ALL_RED` → `GREEN((d+1) mod N_DIR)`. Wrap-around occurs after `N_DIR-1`.
- Phase entry loads `time_left` with that phase's duration. Each tick decrements it.
- Expiry is a tick while `time_left==1`. On that edge the next phase is entered and its duration loaded, so each phase lasts exactly its duration in ticks. `time_left` is never 0 outside `FLASH`.
- `ped_req`=1 on any clock sets `ped_pending`. A request arriving while it is already set is absorbed.
- Shortening: in `GREEN`, with `ped_pending`=1 and `time_left>MIN_GREEN`, load `time_left<=MIN_GREEN` on that edge, whether or not a tick is present.
- `walk`=1 throughout an `ALL_RED` phase that was entered with `ped_pending`=1. `ped_pending` clears on the edge that exits that `ALL_RED`.
- `ped_req` arriving during `ALL_RED` sets `ped_pending` but does not assert `walk` in the current `ALL_RED`. It is served in the next one.
- `FLASH` behaviour:
  - `flash_en`=1 forces `FLASH` on the next edge from any phase.
  - In `FLASH`: `led_r`=`led_g`=0, every `led_y`=`blink`, `walk`=0, `time_left`=0, `ped_pending` held at 0.
  - `blink` is cleared on `FLASH` entry and toggles on each tick.
- `flash_en`=0 while in `FLASH` → enter `ALL_RED` with `active_dir=N_DIR-1` and `time_left=ALLRED_T`. Approach 0 is therefore the next green.
- Lamp decode, per approach `d`:
  - `led_g[d]` = `GREEN` and `active_dir==d`
  - `led_y[d]` = (`YELLOW` and `active_dir==d`) or (`FLASH` and `blink`)
  - `led_r[d]` = not `FLASH` and not `led_g[d]` and not `led_y[d]`
  - Exactly one approach is non-red outside `ALL_RED` and `FLASH`.
- Update priority on a single edge: `rst` > `flash_en` > expiry > pedestrian shortening > tick decrement.

## Timing
- Reset state: `phase=ALL_RED`, `active_dir=N_DIR-1`, `time_left=ALLRED_T`, `ped_pending=0`, `blink=0`, `walk=0`, all `led_r`=1, `led_y`=`led_g`=0.
- First green is approach 0, after `ALLRED_T` ticks.
- All outputs are registered state or pure decode of registered state. A change appears on the same edge that samples `tick`, `ped_req`, or `flash_en`, which is 1-clock latency from input to output.
- A tick on the edge that `rst` deasserts is ignored.
- `rst` asserted mid-phase returns to the reset state on the next edge. A pending request is lost.
- A tick coinciding with shortening is consumed by the shortening; no extra decrement occurs.
- Expiry coinciding with `ped_req` moves to the next phase. `ped_pending` is still set.
- `tick` asserted on consecutive clocks is legal; each pulse counts.

## Structure
- Package `traffic_pkg` holds:
  - `phase_t` enum: `ALL_RED`, `GREEN`, `YELLOW`, `FLASH` with the encodings above, compatible with the `traffic_fsm` encoding RED=00/GREEN=01/YELLOW=10.
  - A `dur_of(phase_t)`-style helper taking durations as arguments.
- Sub-module `phase_timer`: `TW`-wide down-counter with `load`, `load_val`, `tick` inputs and `expire` output (`tick && cnt==1`).
- The top level holds the phase FSM, the direction counter, the pedestrian latch, the blink flop, and lamp decode.

## Test plan
Setup for all scenarios: `N_DIR=3`, `GREEN_T=5`, `YELLOW_T=2`, `ALLRED_T=1`, `MIN_GREEN=2`, `tick` every 4 clocks.

- Reset then free-run 60 ticks → phases follow AR,G0,Y0,AR,G1,Y1,AR,G2,Y2,AR,G0 with lengths 1/5/2 ticks. Exactly one of `led_r`/`led_y`/`led_g` is set per approach at all times, and approach 0 regains green after 24 ticks.
- `ped_req` pulse while in G1 with `time_left=4` → next edge `time_left=2`, `ped_pending=1`. Then Y1 lasts 2 ticks, and `walk=1` for the following 1-tick AR. `ped_pending=0` after that AR, and G2 lasts a full 5.
- `ped_req` while in G0 with `time_left=2` → no change to `time_left`. `walk` asserts in the next AR.
- `flash_en=1` mid-Y1 → next edge `phase=FLASH`, all `led_r`/`led_g`=0, and `led_y` toggles 0/1/0 on successive ticks. Release `flash_en` → AR with `time_left=1`, then G0.
- `rst` held for 1 clock mid-G2 with `ped_pending=1` → reset values on the next edge, including `ped_pending=0`.
- `tick` and `ped_req` on the same clock in G0 with `time_left=5` → `time_left=2`, not 1.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared phase encoding and duration helpers for the traffic controllers.
// The phase encoding stays compatible with the older two-set controller (RED=00, GREEN=01, YELLOW=10).
package traffic_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'b00,
        GREEN   = 2'b01,
        YELLOW  = 2'b10,
        FLASH   = 2'b11
    } phase_t;

    function automatic int dur_of(phase_t p, int green_t, int yellow_t, int allred_t);
        case (p)
            GREEN:   return green_t;
            YELLOW:  return yellow_t;
            ALL_RED: return allred_t;
            default: return 0;
        endcase
    endfunction

    // Normal sequencing only; FLASH entry and exit are decided by the controller itself.
    function automatic phase_t next_phase(phase_t p);
        case (p)
            ALL_RED: return GREEN;
            GREEN:   return YELLOW;
            default: return ALL_RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_ctrl_multi_phase_timer.sv
// Phase down-counter: load wins over tick, and the counter parks at zero.
// Expire is combinational (tick while cnt==1); no backpressure.
module phase_timer #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          tick,
    output logic [TW-1:0] cnt,
    output logic          expire
);

    always_ff @(posedge clk) begin
        if (load) begin
            cnt <= load_val;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign expire = tick && (cnt == TW'(1));

endmodule

// File: rtl/traffic_ctrl_multi.sv
// Multi-approach traffic controller with pedestrian walk and maintenance flash.
// Latency: 1 clock from tick/ped_req/flash_en to outputs; no backpressure (inputs sampled every clock).
module traffic_ctrl_multi
    import traffic_pkg::*;
#(
    parameter int N_DIR     = 2,
    parameter int TW        = 8,
    parameter int GREEN_T   = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int MIN_GREEN = 5,
    localparam int DW       = ($clog2(N_DIR) > 1) ? $clog2(N_DIR) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             ped_req,
    input  logic             flash_en,
    output logic [1:0]       phase,
    output logic [DW-1:0]    active_dir,
    output logic [N_DIR-1:0] led_r,
    output logic [N_DIR-1:0] led_y,
    output logic [N_DIR-1:0] led_g,
    output logic             walk,
    output logic [TW-1:0]    time_left,
    output logic             ped_pending
);

    localparam logic [DW-1:0] LAST_DIR = DW'(N_DIR - 1);

    phase_t        phase_q;
    logic [DW-1:0] active_dir_q;
    logic          ped_pending_q;
    logic          blink_q;
    logic          walk_q;

    logic          load;
    logic [TW-1:0] load_val;
    logic          expire;
    logic          ped_eff;

    // A request on this very edge already counts for shortening and walk.
    assign ped_eff = ped_pending_q | ped_req;

    phase_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .load     (load),
        .load_val (load_val),
        .tick     (tick),
        .cnt      (time_left),
        .expire   (expire)
    );

    always_comb begin
        load     = 1'b0;
        load_val = '0;
        if (rst) begin
            load     = 1'b1;
            load_val = TW'(ALLRED_T);
        end else if (flash_en) begin
            load     = 1'b1;
            load_val = '0;
        end else if (phase_q == FLASH) begin
            load     = 1'b1;
            load_val = TW'(ALLRED_T);
        end else if (expire) begin
            load     = 1'b1;
            load_val = TW'(dur_of(next_phase(phase_q), GREEN_T, YELLOW_T, ALLRED_T));
        end else if ((phase_q == GREEN) && ped_eff && (time_left > TW'(MIN_GREEN))) begin
            load     = 1'b1;
            load_val = TW'(MIN_GREEN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q       <= ALL_RED;
            active_dir_q  <= LAST_DIR;
            ped_pending_q <= 1'b0;
            blink_q       <= 1'b0;
            walk_q        <= 1'b0;
        end else if (flash_en) begin
            phase_q       <= FLASH;
            ped_pending_q <= 1'b0;
            walk_q        <= 1'b0;
            if (phase_q != FLASH) begin
                blink_q <= 1'b0;
            end else if (tick) begin
                blink_q <= ~blink_q;
            end
        end else if (phase_q == FLASH) begin
            // Leaving maintenance: restart as if just after approach N_DIR-1.
            phase_q      <= ALL_RED;
            active_dir_q <= LAST_DIR;
            walk_q       <= 1'b0;
            blink_q      <= 1'b0;
        end else begin
            ped_pending_q <= ped_eff;
            if (expire) begin
                phase_q <= next_phase(phase_q);
                case (phase_q)
                    YELLOW: walk_q <= ped_eff;
                    ALL_RED: begin
                        walk_q       <= 1'b0;
                        active_dir_q <= (active_dir_q == LAST_DIR) ? '0 : active_dir_q + DW'(1);
                        if (walk_q) begin
                            ped_pending_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        led_r = '0;
        led_y = '0;
        led_g = '0;
        for (int d = 0; d < N_DIR; d++) begin
            led_g[d] = (phase_q == GREEN) && (active_dir_q == DW'(d));
            led_y[d] = ((phase_q == YELLOW) && (active_dir_q == DW'(d))) ||
                       ((phase_q == FLASH) && blink_q);
            led_r[d] = (phase_q != FLASH) && !led_g[d] && !led_y[d];
        end
    end

    assign phase       = phase_q;
    assign active_dir  = active_dir_q;
    assign walk        = walk_q;
    assign ped_pending = ped_pending_q;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Bench for traffic_ctrl_multi: directed scenarios plus a randomized run against a phase-level model.
module tb_traffic_ctrl_multi;

    localparam int NDIR = 3;
    localparam int GT   = 5;
    localparam int YT   = 2;
    localparam int AT   = 1;
    localparam int MG   = 2;
    localparam int P_AR = 0, P_G = 1, P_Y = 2, P_F = 3;

    logic       clk = 1'b0;
    logic       rst, tick, ped_req, flash_en;
    logic [1:0] phase;
    logic [1:0] active_dir;
    logic [2:0] led_r, led_y, led_g;
    logic       walk;
    logic [7:0] time_left;
    logic       ped_pending;

    int n_vec = 0;
    int n_err = 0;
    int tcnt  = 0;
    bit last_tick;

    int m_phase, m_dir, m_left;
    bit m_pend, m_walk, m_blink;

    traffic_ctrl_multi #(
        .N_DIR(NDIR), .TW(8), .GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(AT), .MIN_GREEN(MG)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .flash_en(flash_en),
        .phase(phase), .active_dir(active_dir), .led_r(led_r), .led_y(led_y), .led_g(led_g),
        .walk(walk), .time_left(time_left), .ped_pending(ped_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Phase-level reference: what the intersection should do on one clock edge.
    task automatic model_step(input bit r, input bit t, input bit p, input bit f);
        bit pend_now;
        if (r) begin
            m_phase = P_AR; m_dir = NDIR - 1; m_left = AT;
            m_pend = 0; m_walk = 0; m_blink = 0;
        end else if (f) begin
            if (m_phase != P_F) m_blink = 0;
            else if (t) m_blink = !m_blink;
            m_phase = P_F; m_left = 0; m_pend = 0; m_walk = 0;
        end else if (m_phase == P_F) begin
            m_phase = P_AR; m_dir = NDIR - 1; m_left = AT; m_walk = 0; m_blink = 0;
        end else begin
            pend_now = m_pend || p;
            m_pend = pend_now;
            if (t && m_left == 1) begin
                if (m_phase == P_G) begin
                    m_phase = P_Y; m_left = YT;
                end else if (m_phase == P_Y) begin
                    m_phase = P_AR; m_left = AT; m_walk = pend_now;
                end else begin
                    m_phase = P_G; m_left = GT; m_dir = (m_dir + 1) % NDIR;
                    if (m_walk) m_pend = 0;
                    m_walk = 0;
                end
            end else if (m_phase == P_G && pend_now && m_left > MG) begin
                m_left = MG;
            end else if (t) begin
                m_left = m_left - 1;
            end
        end
    endtask

    function automatic logic [22:0] exp_vec();
        logic [2:0] g, y, r;
        for (int d = 0; d < NDIR; d++) begin
            g[d] = (m_phase == P_G) && (m_dir == d);
            y[d] = ((m_phase == P_Y) && (m_dir == d)) || ((m_phase == P_F) && m_blink);
            r[d] = (m_phase != P_F) && !g[d] && !y[d];
        end
        return {2'(m_phase), 2'(m_dir), 8'(m_left), m_pend, m_walk, r, y, g};
    endfunction

    task automatic drive(input bit r, input bit t, input bit p, input bit f);
        rst = r; tick = t; ped_req = p; flash_en = f;
        @(posedge clk);
        model_step(r, t, p, f);
        last_tick = t;
        #1;
    endtask

    // Regular timebase: one tick every fourth clock.
    task automatic clk1(input bit r, input bit p, input bit f);
        bit t;
        t = (tcnt == 3);
        tcnt = (tcnt + 1) % 4;
        drive(r, t, p, f);
    endtask

    // Ticks spent in the current phase/direction segment, including the tick that ends it.
    task automatic measure(output int len, output bit ok);
        logic [1:0] st_ph, st_dr;
        st_ph = phase; st_dr = active_dir; len = 0; ok = 0;
        for (int i = 0; i < 400; i++) begin
            clk1(0, 0, 0);
            if (last_tick) len++;
            if (phase != st_ph || active_dir != st_dr) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        clk1(1, 0, 0);
        n_vec++;
        if ({phase, active_dir, time_left, ped_pending, walk} !== {2'd0, 2'd2, 8'd1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got ph=%0d dir=%0d tl=%0d pend=%0d walk=%0d, want 0/2/1/0/0",
                     phase, active_dir, time_left, ped_pending, walk);
        end
        n_vec++;
        if ({led_r, led_y, led_g} !== {3'b111, 3'b000, 3'b000}) begin
            n_err++;
            $display("FAIL reset_lamps: got r=%b y=%b g=%b, want 111/000/000", led_r, led_y, led_g);
        end
    endtask

    task automatic test_free_run();
        int seg_ticks, ticks_total;
        int seg_len[$], seg_ph[$], seg_dr[$], g0_at[$];
        int exp_ph[10]  = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
        int exp_dr[10]  = '{2, 0, 0, 0, 1, 1, 1, 2, 2, 2};
        int exp_len[10] = '{1, 5, 2, 1, 5, 2, 1, 5, 2, 1};
        logic [1:0] prev_ph, prev_dr;
        clk1(1, 0, 0);
        prev_ph = phase; prev_dr = active_dir;
        seg_ticks = 0; ticks_total = 0;
        while (ticks_total < 60) begin
            clk1(0, 0, 0);
            if (last_tick) ticks_total++;
            for (int d = 0; d < NDIR; d++) begin
                n_vec++;
                if (int'(led_r[d]) + int'(led_y[d]) + int'(led_g[d]) != 1) begin
                    n_err++;
                    $display("FAIL lamp_onehot dir%0d: got r=%b y=%b g=%b, want exactly one lit",
                             d, led_r[d], led_y[d], led_g[d]);
                end
            end
            n_vec++;
            if ({phase, active_dir, time_left, ped_pending, walk, led_r, led_y, led_g} !== exp_vec()) begin
                n_err++;
                $display("FAIL free_run_state: got %h, want %h",
                         {phase, active_dir, time_left, ped_pending, walk, led_r, led_y, led_g}, exp_vec());
            end
            if (phase != prev_ph || active_dir != prev_dr) begin
                seg_len.push_back(seg_ticks + 1);
                seg_ph.push_back(int'(prev_ph));
                seg_dr.push_back(int'(prev_dr));
                seg_ticks = 0;
                if (phase == 2'd1 && active_dir == 2'd0) g0_at.push_back(ticks_total);
                prev_ph = phase; prev_dr = active_dir;
            end else if (last_tick) begin
                seg_ticks++;
            end
        end
        n_vec++;
        if (seg_len.size() < 10 || g0_at.size() < 2) begin
            n_err++;
            $display("FAIL free_run_segments: got %0d segments and %0d G0 entries, want >=10 and >=2",
                     seg_len.size(), g0_at.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_vec++;
                if (seg_ph[i] != exp_ph[i] || seg_dr[i] != exp_dr[i] || seg_len[i] != exp_len[i]) begin
                    n_err++;
                    $display("FAIL free_run_seg%0d: got ph=%0d dir=%0d len=%0d, want ph=%0d dir=%0d len=%0d",
                             i, seg_ph[i], seg_dr[i], seg_len[i], exp_ph[i], exp_dr[i], exp_len[i]);
                end
            end
            n_vec++;
            if (g0_at[0] != AT || g0_at[1] - g0_at[0] != 24) begin
                n_err++;
                $display("FAIL g0_period: got first=%0d period=%0d, want first=%0d period=24",
                         g0_at[0], g0_at[1] - g0_at[0], AT);
            end
        end
    endtask

    task automatic test_ped_shorten();
        int len;
        bit ok;
        clk1(1, 0, 0);
        for (int i = 0; i < 400 && !(phase == 2'd1 && active_dir == 2'd1 && time_left == 8'd4); i++) clk1(0, 0, 0);
        n_vec++;
        if (!(phase == 2'd1 && active_dir == 2'd1 && time_left == 8'd4)) begin
            n_err++;
            $display("FAIL shorten_reach_g1: got ph=%0d dir=%0d tl=%0d, want 1/1/4", phase, active_dir, time_left);
        end
        clk1(0, 1, 0);
        n_vec++;
        if (time_left !== 8'd2 || ped_pending !== 1'b1) begin
            n_err++;
            $display("FAIL shorten_g1: got tl=%0d pend=%0d, want tl=2 pend=1", time_left, ped_pending);
        end
        for (int i = 0; i < 100 && phase != 2'd2; i++) clk1(0, 0, 0);
        measure(len, ok);
        n_vec++;
        if (!ok || len != YT) begin
            n_err++;
            $display("FAIL shorten_y1_len: got %0d (done=%0d), want %0d", len, ok, YT);
        end
        for (int i = 0; i < 20 && phase == 2'd0; i++) begin
            n_vec++;
            if (walk !== 1'b1) begin
                n_err++;
                $display("FAIL walk_in_ar: got walk=%0d, want 1", walk);
            end
            clk1(0, 0, 0);
        end
        n_vec++;
        if (phase !== 2'd1 || active_dir !== 2'd2 || ped_pending !== 1'b0 || walk !== 1'b0) begin
            n_err++;
            $display("FAIL after_walk: got ph=%0d dir=%0d pend=%0d walk=%0d, want 1/2/0/0",
                     phase, active_dir, ped_pending, walk);
        end
        measure(len, ok);
        n_vec++;
        if (!ok || len != GT) begin
            n_err++;
            $display("FAIL g2_full_len: got %0d (done=%0d), want %0d", len, ok, GT);
        end
    endtask

    task automatic test_ped_late();
        clk1(1, 0, 0);
        for (int i = 0; i < 400 && !(phase == 2'd1 && active_dir == 2'd0 && time_left == 8'd2 && tcnt != 3); i++)
            clk1(0, 0, 0);
        clk1(0, 1, 0);
        n_vec++;
        if (time_left !== 8'd2 || ped_pending !== 1'b1) begin
            n_err++;
            $display("FAIL ped_late_g0: got tl=%0d pend=%0d, want tl=2 pend=1", time_left, ped_pending);
        end
        for (int i = 0; i < 100 && phase != 2'd0; i++) clk1(0, 0, 0);
        n_vec++;
        if (phase !== 2'd0 || walk !== 1'b1) begin
            n_err++;
            $display("FAIL ped_late_walk: got ph=%0d walk=%0d, want ph=0 walk=1", phase, walk);
        end
    endtask

    task automatic test_flash();
        int k;
        logic [2:0] want_y;
        clk1(1, 0, 0);
        for (int i = 0; i < 400 && !(phase == 2'd2 && active_dir == 2'd1); i++) clk1(0, 0, 0);
        clk1(0, 0, 1);
        n_vec++;
        if (phase !== 2'd3 || led_r !== 3'b000 || led_g !== 3'b000 || led_y !== 3'b000 || time_left !== 8'd0) begin
            n_err++;
            $display("FAIL flash_entry: got ph=%0d r=%b y=%b g=%b tl=%0d, want 3/000/000/000/0",
                     phase, led_r, led_y, led_g, time_left);
        end
        k = 0;
        for (int i = 0; i < 40 && k < 2; i++) begin
            clk1(0, (i == 1), 1);
            if (last_tick) begin
                k++;
                want_y = (k == 1) ? 3'b111 : 3'b000;
                n_vec++;
                if (led_y !== want_y || led_r !== 3'b000 || led_g !== 3'b000) begin
                    n_err++;
                    $display("FAIL flash_blink%0d: got r=%b y=%b g=%b, want 000/%b/000", k, led_r, led_y, led_g, want_y);
                end
            end
        end
        n_vec++;
        if (ped_pending !== 1'b0 || walk !== 1'b0) begin
            n_err++;
            $display("FAIL flash_ped_held: got pend=%0d walk=%0d, want 0/0", ped_pending, walk);
        end
        clk1(0, 0, 0);
        n_vec++;
        if (phase !== 2'd0 || time_left !== 8'd1 || active_dir !== 2'd2) begin
            n_err++;
            $display("FAIL flash_exit: got ph=%0d tl=%0d dir=%0d, want 0/1/2", phase, time_left, active_dir);
        end
        for (int i = 0; i < 40 && phase == 2'd0; i++) clk1(0, 0, 0);
        n_vec++;
        if (phase !== 2'd1 || active_dir !== 2'd0) begin
            n_err++;
            $display("FAIL flash_then_g0: got ph=%0d dir=%0d, want 1/0", phase, active_dir);
        end
    endtask

    task automatic test_rst_mid();
        clk1(1, 0, 0);
        for (int i = 0; i < 400 && !(phase == 2'd1 && active_dir == 2'd2); i++) clk1(0, 0, 0);
        clk1(0, 1, 0);
        n_vec++;
        if (ped_pending !== 1'b1 || phase !== 2'd1) begin
            n_err++;
            $display("FAIL rst_mid_setup: got pend=%0d ph=%0d, want 1/1", ped_pending, phase);
        end
        clk1(1, 0, 0);
        n_vec++;
        if ({phase, active_dir, time_left, ped_pending, walk, led_r, led_y, led_g} !==
            {2'd0, 2'd2, 8'd1, 1'b0, 1'b0, 3'b111, 3'b000, 3'b000}) begin
            n_err++;
            $display("FAIL rst_mid: got ph=%0d dir=%0d tl=%0d pend=%0d walk=%0d r=%b, want 0/2/1/0/0/111",
                     phase, active_dir, time_left, ped_pending, walk, led_r);
        end
    endtask

    task automatic test_tick_ped();
        clk1(1, 0, 0);
        for (int i = 0; i < 400 && !(phase == 2'd1 && active_dir == 2'd0 && time_left == 8'd5 && tcnt == 3); i++)
            clk1(0, 0, 0);
        clk1(0, 1, 0);
        n_vec++;
        if (time_left !== 8'd2 || last_tick !== 1'b1) begin
            n_err++;
            $display("FAIL tick_with_shorten: got tl=%0d (tick=%0d), want tl=2 with tick", time_left, last_tick);
        end
    endtask

    task automatic test_random();
        bit fl, r, t, p;
        fl = 0;
        clk1(1, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(149, 0) == 0) fl = !fl;
            r = ($urandom_range(399, 0) == 0);
            t = ($urandom_range(1, 0) == 1);
            p = ($urandom_range(9, 0) == 0);
            drive(r, t, p, fl);
            n_vec++;
            if ({phase, active_dir, time_left, ped_pending, walk, led_r, led_y, led_g} !== exp_vec()) begin
                n_err++;
                $display("FAIL random_cyc%0d: got %h, want %h", i,
                         {phase, active_dir, time_left, ped_pending, walk, led_r, led_y, led_g}, exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; ped_req = 1'b0; flash_en = 1'b0;
        test_reset();
        test_free_run();
        test_ped_shorten();
        test_ped_late();
        test_flash();
        test_rst_mid();
        test_tick_ped();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
